iter_alu: RTL and testbench
===========================

ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; the only supported value is 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  operation request; sampled only in IDLE.
REQ-005 op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MOV, 6 MUL, 7 reserved.
REQ-006 set_flags  input  1  request NZCV write-back to the CPSR for this operation.
REQ-007 a, b  input  WIDTH  operands; captured on the accepted start.
REQ-008 Cin, Vin  input  1  current CPSR C and V values, passed through for logical/MUL ops.
REQ-009 result  output  WIDTH  registered result.
REQ-010 Nout, Zout, Cout, Vout  output  1  registered flags, wired to the CPSR Nin/Zin/Cin/Vin inputs.
REQ-011 flag_we  output  1  one-cycle CPSR write strobe.
REQ-012 busy  output  1  high while not in IDLE.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, MUL, DONE; encoding is free.
REQ-015 IDLE with start=1 and op in 0..5: compute combinationally, register result/flags, go to DONE; done=1 in the cycle after start (latency 1).
REQ-016 IDLE with start=1 and op=6: capture a, b; clear the accumulator and counter; go to MUL.
REQ-017 MUL: shift-add, one multiplier bit per cycle, LSB first, 32 cycles; the low 32 bits are kept; then go to DONE; done=1 exactly 33 cycles after the start cycle.
REQ-018 DONE: assert done=1, and flag_we=set_flags (captured at start), for exactly one cycle; return to IDLE.
REQ-019 start in MUL or DONE is ignored; it is not queued.
REQ-020 A new start is accepted in IDLE only; back-to-back single-cycle ops complete at most one every 2 cycles.
REQ-021 op=7: treated as MOV; no error flag.
REQ-022 N=result[31]; Z=(result==0) for all ops.
REQ-023 ADD: C=carry out of bit 31; V=(a[31]==b[31]) and (result[31]!=a[31]).
REQ-024 SUB: result=a-b; C=NOT borrow (1 when a>=b unsigned); V=(a[31]!=b[31]) and (result[31]!=a[31]).
REQ-025 AND/ORR/EOR/MOV(result=b)/MUL: Cout=Cin and Vout=Vin, sampled at the accepted start.
REQ-026 result and flags hold their last values while in IDLE until the next completion.
REQ-027 flag_we is never asserted outside DONE.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE; result=0; Nout=Zout=Cout=Vout=0; flag_we=0; done=0; busy=0; counter and accumulator cleared.
REQ-029 Reset during MUL aborts the operation with no done or flag_we pulse; start in the same cycle as rst is ignored.

Structure
REQ-030 Package alu_pkg holds the op encodings, FSM state encodings and the MUL iteration count (32).
REQ-031 Sub-module iter_mul contains the shift-add datapath and counter, with a load/step/last interface; the FSM and flag logic stay in iter_alu.

Verification
REQ-032 After rst: ADD a=0x7FFFFFFF, b=1, set_flags=1 -> one cycle later result=0x80000000, N=1 Z=0 C=0 V=1, done=flag_we=1 for one cycle.
REQ-033 SUB a=5, b=5 -> result=0, N=0 Z=1 C=1 V=0; SUB a=0, b=1 -> 0xFFFFFFFF, N=1 C=0 V=0.
REQ-034 MUL a=0x00010000, b=0x00010000, Cin=1, Vin=0 -> done at exactly start+33, result=0, Z=1 C=1 V=0; MUL 7*6 -> 42.
REQ-035 start pulsed on cycles 5 and 20 of a MUL -> only one done; result equals the first operation's product.
REQ-036 rst at cycle 10 of a MUL -> no done or flag_we pulse; all outputs 0; the next ADD 2+3 gives 5 with latency 1.
REQ-037 AND a=0xF0, b=0x0F, set_flags=0 -> result=0, Z=1, done=1, flag_we=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and multiply iteration count for iter_alu
package alu_pkg;

    localparam int MUL_ITERS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_ORR = 3'd3,
        OP_EOR = 3'd4,
        OP_MOV = 3'd5,
        OP_MUL = 3'd6,
        OP_RSV = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_mul.sv
// rtl/iter_mul.sv - shift-add multiplier datapath, one multiplier bit per step, LSB first
import alu_pkg::*;

module iter_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] product_next
);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    // Only the low WIDTH bits of the product are kept, so the shifted multiplicand may drop its top bits.
    assign product_next = acc + (mplier[0] ? mcand : '0);
    assign last         = (count == CNT_W'(MUL_ITERS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= product_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - single-cycle ALU ops plus iterative 32-cycle multiply with NZCV flag generation
import alu_pkg::*;

module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             Vin,
    output logic [WIDTH-1:0] result,
    output logic             Nout,
    output logic             Zout,
    output logic             Cout,
    output logic             Vout,
    output logic             flag_we,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic             sf_q;
    logic             c_q;
    logic             v_q;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [WIDTH-1:0] mul_prod;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_res = b;
        alu_c   = Cin;
        alu_v   = Vin;
        case (op_t'(op))
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_ORR:  alu_res = a | b;
            OP_EOR:  alu_res = a ^ b;
            default: alu_res = b;
        endcase
    end

    assign mul_load = (state == ST_IDLE) && start && (op_t'(op) == OP_MUL);
    assign mul_step = (state == ST_MUL);

    iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst          (rst),
        .load         (mul_load),
        .step         (mul_step),
        .a            (a),
        .b            (b),
        .last         (mul_last),
        .product_next (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            result  <= '0;
            Nout    <= 1'b0;
            Zout    <= 1'b0;
            Cout    <= 1'b0;
            Vout    <= 1'b0;
            flag_we <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            sf_q    <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done    <= 1'b0;
                    flag_we <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (op_t'(op) == OP_MUL) begin
                            sf_q  <= set_flags;
                            c_q   <= Cin;
                            v_q   <= Vin;
                            state <= ST_MUL;
                        end else begin
                            result  <= alu_res;
                            Nout    <= alu_res[WIDTH-1];
                            Zout    <= (alu_res == '0);
                            Cout    <= alu_c;
                            Vout    <= alu_v;
                            done    <= 1'b1;
                            flag_we <= set_flags;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        result  <= mul_prod;
                        Nout    <= mul_prod[WIDTH-1];
                        Zout    <= (mul_prod == '0);
                        Cout    <= c_q;
                        Vout    <= v_q;
                        done    <= 1'b1;
                        flag_we <= sf_q;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    flag_we <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    flag_we <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - table-driven and sequence checks for iter_alu
module tb_iter_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        set_flags;
    logic [31:0] a;
    logic [31:0] b;
    logic        Cin;
    logic        Vin;
    logic [31:0] result;
    logic        Nout;
    logic        Zout;
    logic        Cout;
    logic        Vout;
    logic        flag_we;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .set_flags (set_flags),
        .a         (a),
        .b         (b),
        .Cin       (Cin),
        .Vin       (Vin),
        .result    (result),
        .Nout      (Nout),
        .Zout      (Zout),
        .Cout      (Cout),
        .Vout      (Vout),
        .flag_we   (flag_we),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sf;
        logic        cin;
        logic        vin;
        logic [31:0] exp_res;
        logic [3:0]  exp_nzcv;
        logic        exp_fwe;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves start low at the negedge after the accepting posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic sf, input logic ci, input logic vi);
        op = o; a = va; b = vb; set_flags = sf; Cin = ci; Vin = vi;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int cnt;
        cnt = 1;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_latency"}, cnt, exp_cycles);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; op = 3'd0; set_flags = 1'b0;
        a = '0; b = '0; Cin = 1'b0; Vin = 1'b0;

        vecs[0]  = '{3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 4'b1001, 1'b1};
        vecs[1]  = '{3'd1, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b0110, 1'b1};
        vecs[2]  = '{3'd1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1000, 1'b1};
        vecs[3]  = '{3'd2, 32'h0000_00F0, 32'h0000_000F, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'b0111, 1'b0};
        vecs[4]  = '{3'd3, 32'h0000_00F0, 32'h0000_000F, 1'b1, 1'b0, 1'b1, 32'h0000_00FF, 4'b0001, 1'b1};
        vecs[5]  = '{3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 1'b1, 1'b0, 32'hF0F0_0F0F, 4'b1010, 1'b1};
        vecs[6]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0100, 1'b1};
        vecs[7]  = '{3'd7, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 4'b0011, 1'b1};
        vecs[8]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b0110, 1'b1};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b0011, 1'b0};
        vecs[10] = '{3'd0, 32'h0000_0002, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 32'h0000_0005, 4'b0000, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_flags", {28'h0, Nout, Zout, Cout, Vout}, 32'h0);
        check("reset_ctrl", {29'h0, busy, done, flag_we}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sf, vecs[i].cin, vecs[i].vin);
            check($sformatf("v%0d_done", i), {31'h0, done}, 32'h1);
            check($sformatf("v%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("v%0d_nzcv", i), {28'h0, Nout, Zout, Cout, Vout}, {28'h0, vecs[i].exp_nzcv});
            check($sformatf("v%0d_fwe", i), {31'h0, flag_we}, {31'h0, vecs[i].exp_fwe});
            @(negedge clk);
            check($sformatf("v%0d_pulse_end", i), {30'h0, done, flag_we}, 32'h0);
            check($sformatf("v%0d_hold", i), result, vecs[i].exp_res);
        end

        // Multiply whose product overflows the low word entirely
        issue(3'd6, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 1'b0);
        check("mul0_busy", {31'h0, busy}, 32'h1);
        check("mul0_no_fwe_early", {31'h0, flag_we}, 32'h0);
        wait_done("mul0", 33);
        check("mul0_result", result, 32'h0);
        check("mul0_nzcv", {28'h0, Nout, Zout, Cout, Vout}, 32'h6);
        check("mul0_fwe", {31'h0, flag_we}, 32'h1);
        @(negedge clk);
        check("mul0_pulse_end", {29'h0, done, flag_we, busy}, 32'h0);

        issue(3'd6, 32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
        wait_done("mul1", 33);
        check("mul1_result", result, 32'd42);
        check("mul1_nzcv", {28'h0, Nout, Zout, Cout, Vout}, 32'h1);
        check("mul1_fwe", {31'h0, flag_we}, 32'h0);
        @(negedge clk);

        // Starts during a multiply must be dropped, not queued
        issue(3'd6, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0);
        dones = 0;
        for (int c = 1; c < 60; c++) begin
            if (c == 5 || c == 20) begin
                op = 3'd0; a = 32'd100; b = 32'd100; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dones++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_start_dones", dones, 32'd1);
        check("ignore_start_result", result, 32'd15);

        // Reset in the middle of a multiply, with a start asserted alongside it
        issue(3'd6, 32'd9, 32'd9, 1'b1, 1'b1, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || flag_we || busy) dones++;
            @(negedge clk);
        end
        check("rst_abort_no_activity", dones, 32'd0);
        check("rst_abort_result", result, 32'h0);
        check("rst_abort_flags", {28'h0, Nout, Zout, Cout, Vout}, 32'h0);
        issue(3'd0, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
        check("post_rst_add_done", {31'h0, done}, 32'h1);
        check("post_rst_add_result", result, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
